// File: rtl/writeback_regfile.sv
// writeback_regfile
//   Writeback stage that sits directly after the memory stage. It takes the packed
//   memory-stage result {is_store, value, rd}, commits non-store results into a
//   NREG x DW register file and counts retired instructions. A per-register
//   pending-write scoreboard holds decode back on RAW hazards and when a
//   register already has CNT_MAX writes in flight.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   wb_valid        wb_in carries a real instruction this cycle
//   wb_in           {is_store, value[DW-1:0], rd[AW-1:0]}
//   issue_valid     decode issues an instruction that writes iss_rd
//   iss_rd          destination register of the issuing instruction
//   rs1, rs2        decode source register addresses
//   rdata1, rdata2  source values, bypassed from the commit in this cycle
//   stall           decode must hold; the issue is ignored while high
//   wb_rd, wb_we    registered trace of the last commit
//   retired         number of wb_valid cycles, stores included, wrapping
module writeback_regfile #(
  parameter  int NREG = 8,
  parameter  int DW   = 16,
  parameter  int CNTW = 2,
  parameter  int RETW = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [DW+AW:0]  wb_in,
  input  logic            issue_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [DW-1:0]   rdata1,
  output logic [DW-1:0]   rdata2,
  output logic            stall,
  output logic [AW-1:0]   wb_rd,
  output logic            wb_we,
  output logic [RETW-1:0] retired
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [DW-1:0]   reg_q [NREG];
  logic [DW-1:0]   reg_d [NREG];
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [RETW-1:0] retired_q, retired_d;
  logic            wb_we_q, wb_we_d;
  logic [AW-1:0]   wb_rd_q, wb_rd_d;

  logic            wb_is_store;
  logic [DW-1:0]   wb_value;
  logic [AW-1:0]   wb_addr;
  logic            do_wr;
  logic            dec;
  logic            inc;
  logic            sat;

  assign wb_is_store = wb_in[DW+AW];
  assign wb_value    = wb_in[DW+AW-1:AW];
  assign wb_addr     = wb_in[AW-1:0];

  // A source is hazardous while writes to it are pending, except when the only
  // pending write commits this very cycle: the bypass already delivers it.
  function automatic logic hazard(input logic [AW-1:0]   r,
                                  input logic [CNTW-1:0] c,
                                  input logic            dec_v,
                                  input logic [AW-1:0]   dec_addr);
    return (r != '0) && (c != '0) && !(dec_v && (dec_addr == r) && (c == CNT_ONE));
  endfunction

  always_comb begin
    do_wr = wb_valid && !wb_is_store && (wb_addr != '0);
    // Pre-reset instructions can commit with an empty counter: no underflow.
    dec   = do_wr && (cnt_q[wb_addr] != '0);
    sat   = (iss_rd != '0) && (cnt_q[iss_rd] == CNT_MAX);
    stall = hazard(rs1, cnt_q[rs1], dec, wb_addr) ||
            hazard(rs2, cnt_q[rs2], dec, wb_addr) || sat;
    inc   = issue_valid && !stall && (iss_rd != '0);

    if (rs1 == '0)                         rdata1 = '0;
    else if (do_wr && (wb_addr == rs1))    rdata1 = wb_value;
    else                                   rdata1 = reg_q[rs1];

    if (rs2 == '0)                         rdata2 = '0;
    else if (do_wr && (wb_addr == rs2))    rdata2 = wb_value;
    else                                   rdata2 = reg_q[rs2];
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      reg_d[r] = reg_q[r];
      cnt_d[r] = cnt_q[r];
      // r0 is never written (do_wr excludes it), so it stays at its reset value.
      if (do_wr && (wb_addr == AW'(r))) reg_d[r] = wb_value;
      // Increment and decrement of the same register cancel out.
      if (inc && (iss_rd == AW'(r)) && !(dec && (wb_addr == AW'(r))))
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && (wb_addr == AW'(r)) && !(inc && (iss_rd == AW'(r))))
        cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
    retired_d = wb_valid ? retired_q + RETW'(1) : retired_q;
    wb_we_d   = do_wr;
    wb_rd_d   = do_wr ? wb_addr : wb_rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      retired_q <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r] <= reg_d[r];
        cnt_q[r] <= cnt_d[r];
      end
      retired_q <= retired_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  assign retired = retired_q;
  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile
//   Randomized and directed stimulus for writeback_regfile, checked against a
//   behavioural model (integer register array, pending-write counts, retired count).
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [19:0] wb_in;
  logic        issue_valid;
  logic [2:0]  iss_rd;
  logic [2:0]  rs1, rs2;
  logic [15:0] rdata1, rdata2;
  logic        stall;
  logic [2:0]  wb_rd;
  logic        wb_we;
  logic [15:0] retired;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_in(wb_in),
    .issue_valid(issue_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2), .stall(stall),
    .wb_rd(wb_rd), .wb_we(wb_we), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int m_reg [8];
  int m_cnt [8];
  int m_ret;
  int m_we;
  int m_rd;

  // Values seen at the sampling point of the most recent cycle
  logic [15:0] obs_r1, obs_r2;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 0;
      m_cnt[i] = 0;
    end
    m_ret = 0;
    m_we  = 0;
    m_rd  = 0;
  endtask

  function automatic int exp_read(input int r, input bit commit, input int rd, input int val);
    if (r == 0) return 0;
    if (commit && rd == r) return val;
    return m_reg[r];
  endfunction

  function automatic bit src_blocked(input int r, input bit commit, input int rd);
    bit last_commit;
    if (r == 0 || m_cnt[r] == 0) return 0;
    last_commit = commit && (rd == r) && (m_cnt[r] == 1);
    return !last_commit;
  endfunction

  // One clock cycle: drive, sample at the falling edge, advance the model.
  task automatic cycle(input string tag, input bit v, input bit st, input int val,
                       input int rd, input bit iv, input int ird, input int r1, input int r2);
    bit commit, es;
    int e1, e2;
    wb_valid    = v;
    wb_in       = {st, val[15:0], rd[2:0]};
    issue_valid = iv;
    iss_rd      = ird[2:0];
    rs1         = r1[2:0];
    rs2         = r2[2:0];
    @(negedge clk);
    commit = v && !st && rd != 0;
    e1 = exp_read(r1, commit, rd, val);
    e2 = exp_read(r2, commit, rd, val);
    es = src_blocked(r1, commit, rd) || src_blocked(r2, commit, rd) ||
         (ird != 0 && m_cnt[ird] == 3);
    check("rdata1", 32'(rdata1), 32'(e1));
    check("rdata2", 32'(rdata2), 32'(e2));
    check("stall", 32'(stall), 32'(es));
    check("retired", 32'(retired), 32'(m_ret));
    check("wb_we", 32'(wb_we), 32'(m_we));
    check("wb_rd", 32'(wb_rd), 32'(m_rd));
    obs_r1    = rdata1;
    obs_r2    = rdata2;
    obs_stall = stall;
    if (tag != "")
      $display("[%s] v=%0d st=%0d val=%04h rd=%0d iv=%0d ird=%0d rs=%0d/%0d -> r1=%04h r2=%04h stall=%0d ret=%0d",
               tag, v, st, val[15:0], rd, iv, ird, r1, r2, rdata1, rdata2, stall, retired);
    // Commit, then scoreboard: pending writes committed, new writes issued.
    if (commit) begin
      m_reg[rd] = val & 16'hFFFF;
      if (m_cnt[rd] > 0) m_cnt[rd] = m_cnt[rd] - 1;
    end
    if (iv && !es && ird != 0) m_cnt[ird] = m_cnt[ird] + 1;
    if (v) m_ret = (m_ret + 1) % 65536;
    m_we = commit;
    if (commit) m_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input string tag);
    cycle(tag, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, int'($urandom_range(0, 65535)),
          int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
  endtask

  initial begin
    int ret0;
    rst = 1'b1;
    wb_valid = 1'b0; wb_in = '0; issue_valid = 1'b0; iss_rd = '0;
    rs1 = 3'd1; rs2 = 3'd2;
    model_reset();
    #2;
    check("rst_rdata1", 32'(rdata1), 32'h0);
    check("rst_rdata2", 32'(rdata2), 32'h0);
    check("rst_retired", 32'(retired), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_wb_we", 32'(wb_we), 32'h0);
    check("rst_wb_rd", 32'(wb_rd), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Commit with same-cycle bypass, then read from the file
    cycle("t2_wr", 1, 0, 'hBEEF, 5, 0, 0, 5, 0);
    check("t2_bypass", 32'(obs_r1), 32'hBEEF);
    cycle("t2_rd", 0, 0, 0, 0, 0, 0, 5, 0);
    check("t2_file", 32'(obs_r1), 32'hBEEF);

    // r0 is never written, stores do not write, both retire
    cycle("t3_pre", 1, 0, 'h7777, 2, 0, 0, 0, 0);
    ret0 = retired;
    cycle("t3_r0", 1, 0, 'h1234, 0, 0, 0, 0, 0);
    cycle("t3_st", 1, 1, 'h5555, 2, 0, 0, 0, 2);
    check("t3_retired", 32'(retired), 32'((ret0 + 2) % 65536));
    cycle("t3_rd", 0, 0, 0, 0, 0, 0, 0, 2);
    check("t3_r0", 32'(obs_r1), 32'h0);
    check("t3_r2", 32'(obs_r2), 32'h7777);

    // RAW stall and its release by the bypassed commit
    cycle("t4_iss", 0, 0, 0, 0, 1, 3, 0, 0);
    cycle("t4_raw", 0, 0, 0, 0, 0, 0, 3, 0);
    check("t4_stall", 32'(obs_stall), 32'h1);
    cycle("t4_cmt", 1, 0, 'h00AA, 3, 0, 0, 3, 0);
    check("t4_nostall", 32'(obs_stall), 32'h0);
    check("t4_bypass", 32'(obs_r1), 32'h00AA);

    // Saturation of the pending counter and simultaneous issue + commit
    for (int i = 0; i < 3; i++) cycle("t5_iss", 0, 0, 0, 0, 1, 4, 0, 0);
    cycle("t5_full", 0, 0, 0, 0, 1, 4, 0, 0);
    check("t5_sat", 32'(obs_stall), 32'h1);
    cycle("t5_cmt", 1, 0, 'h0001, 4, 0, 0, 0, 0);
    cycle("t5_both", 1, 0, 'h0002, 4, 1, 4, 0, 0);
    check("t5_both_go", 32'(obs_stall), 32'h0);
    cycle("t5_refill", 0, 0, 0, 0, 1, 4, 0, 0);
    check("t5_refill_go", 32'(obs_stall), 32'h0);
    cycle("t5_full2", 0, 0, 0, 0, 1, 4, 0, 0);
    check("t5_sat2", 32'(obs_stall), 32'h1);
    for (int i = 0; i < 3; i++) cycle("t5_drain", 1, 0, 'h0010 + i, 4, 0, 0, 4, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) rand_cycle("");

    // Asynchronous reset in the middle of a cycle
    wb_valid = 1'b0; issue_valid = 1'b0; rs1 = 3'd5; rs2 = 3'd3;
    #2;
    rst = 1'b1;
    #1;
    check("t1_rdata1", 32'(rdata1), 32'h0);
    check("t1_rdata2", 32'(rdata2), 32'h0);
    check("t1_retired", 32'(retired), 32'h0);
    check("t1_stall", 32'(stall), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Traffic after reset, including commits with empty counters
    for (int i = 0; i < 300; i++) rand_cycle("");

    // Retired counter wrap
    while (m_ret != 16'hFFFF)
      cycle("", 1, 1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)), 0, 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    check("t6_ffff", 32'(retired), 32'hFFFF);
    cycle("t6_wrap", 1, 1, 0, 1, 0, 0, 0, 0);
    check("t6_wrap", 32'(retired), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
